regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (rd_addr/rd_data/rd_wr_en) among NUM_REQ writeback requesters.

---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port among NUM_REQ
//            writeback requesters. Port 0 (in-order pipeline writeback) has
//            fixed priority. Ports 1..NUM_REQ-1 (long-latency units) rotate
//            round-robin. A starvation guard forces a port>=1 grant after
//            STARVE_LIMIT consecutive port-0 wins while others wait. The
//            winner is registered and drives the write port one cycle later.
// Ports    : clk, rstn (sync, active-low)
//            req_valid/req_addr/req_data : per-requester write request (in)
//            req_ready                   : one-hot-or-zero grant (out, comb)
//            rd_addr/rd_data/rd_wr_en    : registered register-file write
//            starved                     : starvation override active (comb)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NUM_REQ             = 3,
    parameter int STARVE_LIMIT        = 4,
    parameter int XLEN                = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*REG_FILE_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]                req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [REG_FILE_ADDR_WIDTH-1:0]         rd_addr,
    output logic [XLEN-1:0]                        rd_data,
    output logic                                   rd_wr_en,
    output logic                                   starved
);

    localparam int c_AW    = REG_FILE_ADDR_WIDTH;
    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CNT_W-1:0] c_LIMIT     = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_PTR_W-1:0] c_PTR_FIRST = c_PTR_W'(1);

    // rr_ptr only ever holds 1..NUM_REQ-1; port 0 is outside the rotation.
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_CNT_W-1:0] r_starve_cnt;

    logic               w_any_hi;
    logic [NUM_REQ-1:0] w_rr_onehot;
    logic [c_PTR_W-1:0] w_rr_next;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_hi;
    logic               w_starved;
    logic [c_AW-1:0]    w_sel_addr;
    logic [XLEN-1:0]    w_sel_data;

    assign w_any_hi = |req_valid[NUM_REQ-1:1];

    // Round-robin pick: each port>=1 gets its position in the search order
    // starting at rr_ptr; the valid port with the smallest position wins.
    always_comb begin
        int v_best;
        int v_dist;
        v_best      = NUM_REQ;
        v_dist      = 0;
        w_rr_onehot = '0;
        w_rr_next   = r_rr_ptr;
        for (int i = 1; i < NUM_REQ; i++) begin
            if (i >= int'(r_rr_ptr)) begin
                v_dist = i - int'(r_rr_ptr);
            end else begin
                v_dist = i - int'(r_rr_ptr) + (NUM_REQ - 1);
            end
            if (req_valid[i] && (v_dist < v_best)) begin
                v_best         = v_dist;
                w_rr_onehot    = '0;
                w_rr_onehot[i] = 1'b1;
                w_rr_next      = (i == NUM_REQ - 1) ? c_PTR_FIRST : c_PTR_W'(i + 1);
            end
        end
    end

    // Grant: starvation override, then port 0, then the round-robin pick.
    // w_rr_onehot is zero when no port>=1 is valid, so the fall-through
    // branch also covers the "no grant" case.
    always_comb begin
        w_starved = (r_starve_cnt == c_LIMIT) && w_any_hi;
        w_grant   = '0;
        if (w_starved) begin
            w_grant = w_rr_onehot;
        end else if (req_valid[0]) begin
            w_grant[0] = 1'b1;
        end else begin
            w_grant = w_rr_onehot;
        end
    end

    assign w_grant_hi = |w_grant[NUM_REQ-1:1];
    assign req_ready  = w_grant;
    assign starved    = w_starved;

    // Winner's address/data; grant is one-hot so an OR-style mux suffices.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*c_AW +: c_AW];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_addr      <= '0;
            rd_data      <= '0;
            rd_wr_en     <= 1'b0;
            r_rr_ptr     <= c_PTR_FIRST;
            r_starve_cnt <= '0;
        end else begin
            // x0 writes are accepted and latched, but never strobed.
            if (|w_grant) begin
                rd_addr  <= w_sel_addr;
                rd_data  <= w_sel_data;
                rd_wr_en <= (w_sel_addr != '0);
            end else begin
                rd_wr_en <= 1'b0;
            end

            if (w_grant_hi) begin
                r_rr_ptr <= w_rr_next;
            end

            // Counts port-0 wins only while some port>=1 is actually waiting.
            if (w_grant_hi || !w_any_hi) begin
                r_starve_cnt <= '0;
            end else if (w_grant[0] && (r_starve_cnt != c_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter. A behavioural model
//            (integer pointer/counter plus expected output register) is
//            compared against the DUT every cycle; directed scenarios pin the
//            model with literal expectations; a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N   = 3;
    localparam int LIM = 4;
    localparam int XL  = 32;
    localparam int AW  = 5;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*XL-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rd_addr;
    logic [XL-1:0]   rd_data;
    logic            rd_wr_en;
    logic            starved;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NUM_REQ             (N),
        .STARVE_LIMIT        (LIM),
        .XLEN                (XL),
        .REG_FILE_ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_wr_en  (rd_wr_en),
        .starved   (starved)
    );

    // Requester-side stimulus
    logic [N-1:0]  vld;
    logic [AW-1:0] t_addr [N];
    logic [XL-1:0] t_data [N];

    // Behavioural model state
    int            m_rr   = 1;
    int            m_cnt  = 0;
    logic [AW-1:0] m_addr = '0;
    logic [XL-1:0] m_data = '0;
    logic          m_we   = 1'b0;
    logic [XL-1:0] regs [32];

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_acc   = 0;
    int n_pulse = 0;

    logic [N-1:0] seen_rdy;
    logic         seen_stv;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational grant at negedge, advance
    // the model at the posedge, check the registered write port just after.
    task automatic step();
        int           pick;
        int           g;
        bit           any_hi;
        bit           stv;
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = t_addr[i];
            req_data[i*XL +: XL] = t_data[i];
        end
        req_valid = vld;

        @(negedge clk);
        pick   = -1;
        any_hi = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            int p;
            p = 1 + ((m_rr - 1 + k) % (N - 1));
            if (vld[p]) begin
                any_hi = 1'b1;
                if (pick < 0) pick = p;
            end
        end
        stv = (m_cnt == LIM) && any_hi;
        if (stv)         g = pick;
        else if (vld[0]) g = 0;
        else             g = pick;
        e = '0;
        if (g >= 0) e = N'(1) << g;
        chk("req_ready", req_ready, e);
        chk("starved", starved, stv);
        chk("ready_onehot0", $onehot0(req_ready), 1);
        seen_rdy = req_ready;
        seen_stv = starved;

        @(posedge clk);
        if (!rstn) begin
            m_rr   = 1;
            m_cnt  = 0;
            m_addr = '0;
            m_data = '0;
            m_we   = 1'b0;
        end else begin
            m_we = 1'b0;
            if (g >= 0) begin
                m_addr = t_addr[g];
                m_data = t_data[g];
                m_we   = (t_addr[g] != '0);
                if (m_we) begin
                    n_acc++;
                    regs[m_addr] = m_data;
                end
            end
            if (g >= 1) begin
                m_rr  = (g + 1 >= N) ? 1 : g + 1;
                m_cnt = 0;
            end else if (!any_hi) begin
                m_cnt = 0;
            end else if (g == 0 && m_cnt < LIM) begin
                m_cnt++;
            end
        end

        #1;
        chk("rd_wr_en", rd_wr_en, m_we);
        chk("rd_addr", rd_addr, m_addr);
        chk("rd_data", rd_data, m_data);
        if (rd_wr_en) n_pulse++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        vld  = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    logic [N-1:0]  exp_rdy [6];
    logic          exp_stv [6];
    logic [AW-1:0] exp_ad  [4];
    bit            pend    [N];

    initial begin
        vld = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
            pend[i]   = 1'b0;
        end
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // 1: reset state, then a single port-0 write
        do_reset();
        step();
        chk("t1_reset_wr_en", rd_wr_en, 0);
        chk("t1_reset_addr", rd_addr, 0);
        chk("t1_reset_ready", seen_rdy, 0);
        vld = 3'b001; t_addr[0] = 5'd5; t_data[0] = 32'hDEADBEEF;
        step();
        chk("t1_ready", seen_rdy, 3'b001);
        chk("t1_wr_en", rd_wr_en, 1);
        chk("t1_addr", rd_addr, 5);
        chk("t1_data", rd_data, 32'hDEADBEEF);
        vld = '0;
        step();
        chk("t1_idle_wr_en", rd_wr_en, 0);

        // 2: ports 1 and 2 alternate, starting at port 1
        do_reset();
        exp_rdy[0] = 3'b010; exp_rdy[1] = 3'b100; exp_rdy[2] = 3'b010; exp_rdy[3] = 3'b100;
        exp_ad[0] = 5'd6; exp_ad[1] = 5'd7; exp_ad[2] = 5'd6; exp_ad[3] = 5'd7;
        vld = 3'b110; t_addr[1] = 5'd6; t_addr[2] = 5'd7; t_data[1] = 32'h61; t_data[2] = 32'h72;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t2_ready", seen_rdy, exp_rdy[c]);
            chk("t2_wr_en", rd_wr_en, 1);
            chk("t2_addr", rd_addr, exp_ad[c]);
        end

        // 3: starvation guard
        do_reset();
        for (int c = 0; c < 6; c++) begin
            exp_rdy[c] = 3'b001;
            exp_stv[c] = 1'b0;
        end
        exp_rdy[4] = 3'b010; exp_stv[4] = 1'b1;
        vld = 3'b011; t_addr[0] = 5'd1; t_addr[1] = 5'd2; t_data[0] = 32'h10; t_data[1] = 32'h20;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t3_ready", seen_rdy, exp_rdy[c]);
            chk("t3_starved", seen_stv, exp_stv[c]);
            if (c == 4) chk("t3_model_cnt", m_cnt, 0);
        end

        // 4: x0 write accepted but not strobed
        do_reset();
        vld = 3'b001; t_addr[0] = 5'd0; t_data[0] = 32'h1234;
        step();
        chk("t4_ready", seen_rdy, 3'b001);
        chk("t4_x0_wr_en", rd_wr_en, 0);
        t_addr[0] = 5'd3;
        step();
        chk("t4_wr_en", rd_wr_en, 1);
        chk("t4_addr", rd_addr, 3);

        // 5: same destination from ports 1 and 2, later grant wins
        do_reset();
        vld = 3'b110; t_addr[1] = 5'd9; t_addr[2] = 5'd9; t_data[1] = 32'hA; t_data[2] = 32'hB;
        step();
        chk("t5_ready_a", seen_rdy, 3'b010);
        chk("t5_data_a", rd_data, 32'hA);
        vld = 3'b100;
        step();
        chk("t5_ready_b", seen_rdy, 3'b100);
        chk("t5_data_b", rd_data, 32'hB);
        chk("t5_addr_b", rd_addr, 9);
        chk("t5_model_x9", regs[9], 32'hB);

        // 6: reset mid-operation
        do_reset();
        vld = 3'b100; t_addr[2] = 5'd12; t_data[2] = 32'h55;
        step();
        chk("t6_ready", seen_rdy, 3'b100);
        rstn = 1'b0; vld = '0;
        step();
        chk("t6_rst_wr_en", rd_wr_en, 0);
        rstn = 1'b1; vld = 3'b100;
        step();
        chk("t6_repr_ready", seen_rdy, 3'b100);
        chk("t6_repr_addr", rd_addr, 12);
        vld = '0;
        step();
        chk("t6_once_wr_en", rd_wr_en, 0);
        vld = 3'b010; t_addr[1] = 5'd4;
        step();
        rstn = 1'b0; vld = '0;
        step();
        rstn = 1'b1; vld = 3'b110;
        step();
        chk("t6_rr_reset", seen_rdy, 3'b010);

        // Randomized traffic with occasional resets; requesters hold until
        // accepted and re-present anything granted during a reset cycle.
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            rstn = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < ((i == 0) ? ((c < 600) ? 85 : 50) : 35))) begin
                    pend[i]   = 1'b1;
                    t_addr[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    t_data[i] = $urandom;
                end
                vld[i] = pend[i];
            end
            step();
            if (rstn) begin
                for (int i = 0; i < N; i++) begin
                    if (seen_rdy[i]) pend[i] = 1'b0;
                end
            end
        end
        rstn = 1'b1;
        vld  = '0;
        step();

        chk("accepted_vs_pulses", n_pulse, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
